// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the tagged branch target buffer:
//   - 2-bit saturating counter encodings (strongly/weakly not-taken/taken)
//   - RV32 control-transfer opcodes used by the decoder to form upd_is_ctrl
//   - per-entry control fields (valid + counter). These are the only entry
//     fields that reset touches. Tag and target are added in the top module
//     because their widths depend on its parameters.
// -----------------------------------------------------------------------------
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } btb_ctl_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// -----------------------------------------------------------------------------
// btb_sat_ctr
// Combinational next-state function of a 2-bit saturating direction counter.
// Ports:
//   ctr      in  2  current counter value
//   taken    in  1  resolved direction
//   ctr_next out 2  counter +1 on taken (holds at 11), -1 on not-taken
//                   (holds at 00)
// -----------------------------------------------------------------------------
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_tagged_predictor.sv
// -----------------------------------------------------------------------------
// btb_tagged_predictor
// Direct-mapped, tagged branch target buffer with per-entry 2-bit saturating
// counters. The fetch side does a combinational lookup and produces the next
// fetch PC. The EX side detects mispredictions, drives a redirect PC, and
// updates the table on the rising clock edge.
//
// Parameters: PC_W (PC width, arithmetic wraps mod 2^PC_W), ENTRIES (power of
// two). IDX_W and TAG_W are derived.
//
// Ports:
//   CLK, RST          clock (posedge) and synchronous active-high reset
//   pc                fetch PC to look up
//   pred_taken        hit and counter predicts taken
//   pred_target       target of the hit entry, 0 on miss
//   next_pc           redirect_pc on mispredict, else predicted target or pc+4
//   upd_valid         EX instruction valid and not stalled
//   upd_pc            PC of the EX instruction
//   upd_is_ctrl       EX instruction is a branch/JAL/JALR
//   upd_taken         resolved direction
//   upd_target        resolved target
//   upd_pred_taken    prediction carried with the instruction
//   upd_pred_target   predicted target carried with the instruction
//   mispredict        redirect request
//   redirect_pc       corrected PC (always driven)
//
// Optional build macro BTB_STATS_EN adds saturating 32-bit counters
// stat_ctrl (control instructions resolved) and stat_mispred (mispredicts).
// -----------------------------------------------------------------------------
module btb_tagged_predictor
  import btb_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int ENTRIES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [PC_W-1:0] next_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_is_ctrl,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_ctrl,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  typedef struct packed {
    btb_ctl_t          ctl;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   target;
  } btb_entry_t;

  btb_entry_t table_q [ENTRIES];

  // Fetch-side lookup. The table read is the registered state, so an update
  // landing on the same index this cycle is not visible until the next one.
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  assign l_idx = pc[IDX_W+1:2];
  assign l_tag = pc[PC_W-1:IDX_W+2];
  // Gating with RST makes the table look cold for the whole reset cycle.
  assign l_hit = !RST && table_q[l_idx].ctl.valid && (table_q[l_idx].tag == l_tag);

  assign pred_taken  = l_hit && table_q[l_idx].ctl.ctr[1];
  assign pred_target = l_hit ? table_q[l_idx].target : '0;

  // EX-side resolution.
  logic ctrl_taken;
  logic dir_wrong;
  logic tgt_wrong;
  logic stale_hit;

  assign ctrl_taken = upd_is_ctrl && upd_taken;
  assign dir_wrong  = upd_is_ctrl && (upd_taken != upd_pred_taken);
  assign tgt_wrong  = ctrl_taken && upd_pred_taken && (upd_target != upd_pred_target);
  // A non-control instruction that was predicted taken hit an aliased or
  // stale entry; it must fall through and the entry is dropped.
  assign stale_hit  = !upd_is_ctrl && upd_pred_taken;

  assign mispredict  = !RST && upd_valid && (dir_wrong || tgt_wrong || stale_hit);
  assign redirect_pc = ctrl_taken ? upd_target : upd_pc + PC_INC;
  assign next_pc     = mispredict ? redirect_pc :
                       (pred_taken ? pred_target : pc + PC_INC);

  // Update path.
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       ctr_next;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];
  assign u_hit = table_q[u_idx].ctl.valid && (table_q[u_idx].tag == u_tag);

  btb_sat_ctr u_sat_ctr (
    .ctr      (table_q[u_idx].ctl.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  // Table write stage: only valid/ctr are reset; tag/target are don't-care
  // while the entry is invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].ctl.valid <= 1'b0;
        table_q[i].ctl.ctr   <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_is_ctrl) begin
        if (u_hit) begin
          table_q[u_idx].ctl.ctr <= ctr_next;
          if (upd_taken) table_q[u_idx].target <= upd_target;
        end else if (upd_taken) begin
          // Allocate-on-taken, evicting whatever alias occupied the slot.
          table_q[u_idx].ctl.valid <= 1'b1;
          table_q[u_idx].ctl.ctr   <= CTR_WT;
          table_q[u_idx].tag       <= u_tag;
          table_q[u_idx].target    <= upd_target;
        end
      end else if (u_hit) begin
        table_q[u_idx].ctl.valid <= 1'b0;
      end
    end
  end

`ifdef BTB_STATS_EN
  // Statistics stage: saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_ctrl    <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd_valid && upd_is_ctrl && (stat_ctrl != 32'hFFFF_FFFF))
        stat_ctrl <= stat_ctrl + 32'd1;
      if (mispredict && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_tagged_predictor.sv
module tb_btb_tagged_predictor;

  localparam int PC_W    = 12;
  localparam int ENTRIES = 64;
  localparam int PC_MOD  = 1 << PC_W;

  logic            CLK = 1'b0;
  logic            RST;
  logic [PC_W-1:0] pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic [PC_W-1:0] next_pc;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_is_ctrl;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic [PC_W-1:0] upd_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0]     stat_ctrl;
  logic [31:0]     stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  btb_tagged_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .next_pc         (next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_ctrl     (upd_is_ctrl),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BTB_STATS_EN
    ,
    .stat_ctrl       (stat_ctrl),
    .stat_mispred    (stat_mispred)
`endif
  );

  // ---------------- reference model (plain integers) ----------------
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_stat_ctrl = 0;
  int m_stat_mis  = 0;

  function automatic int f_idx(int p); return (p / 4) % ENTRIES; endfunction
  function automatic int f_tag(int p); return p / (4 * ENTRIES); endfunction
  function automatic bit m_hit(int p);
    return m_valid[f_idx(p)] && (m_tag[f_idx(p)] == f_tag(p));
  endfunction
  function automatic bit m_ptaken(int p);
    return !RST && m_hit(p) && (m_ctr[f_idx(p)] >= 2);
  endfunction
  function automatic int m_ptarget(int p);
    return (!RST && m_hit(p)) ? m_tgt[f_idx(p)] : 0;
  endfunction
  function automatic bit m_mis();
    if (RST || !upd_valid) return 1'b0;
    if (upd_is_ctrl && (upd_taken != upd_pred_taken)) return 1'b1;
    if (upd_is_ctrl && upd_taken && upd_pred_taken && (upd_target != upd_pred_target)) return 1'b1;
    if (!upd_is_ctrl && upd_pred_taken) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int m_redirect();
    if (upd_is_ctrl && upd_taken) return int'(upd_target);
    return (int'(upd_pc) + 4) % PC_MOD;
  endfunction
  function automatic int m_next();
    if (m_mis()) return m_redirect();
    if (m_ptaken(int'(pc))) return m_ptarget(int'(pc));
    return (int'(pc) + 4) % PC_MOD;
  endfunction

  task automatic drive_upd(input bit v, input int p, input bit c, input bit t,
                           input int tg, input bit pt, input int ptg);
    upd_valid       = v;
    upd_pc          = PC_W'(p);
    upd_is_ctrl     = c;
    upd_taken       = t;
    upd_target      = PC_W'(tg);
    upd_pred_taken  = pt;
    upd_pred_target = PC_W'(ptg);
  endtask

  // Advance one clock; the model applies the same edge the DUT sees.
  task automatic tick();
    int u, i;
    @(posedge CLK);
    if (RST) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; end
      m_stat_ctrl = 0;
      m_stat_mis  = 0;
    end else if (upd_valid) begin
      u = int'(upd_pc);
      i = f_idx(u);
      if (upd_is_ctrl) m_stat_ctrl++;
      if (m_mis()) m_stat_mis++;
      if (upd_is_ctrl) begin
        if (m_hit(u)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = int'(upd_target);
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1; m_tag[i] = f_tag(u); m_tgt[i] = int'(upd_target); m_ctr[i] = 2;
        end
      end else if (m_hit(u)) begin
        m_valid[i] = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; pc = 12'h100;
    drive_upd(1, 'h100, 0, 0, 0, 1, 'h040);
    tick();
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %0h exp 0", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0h exp 0", pred_taken); end
    checks++; if (pred_target !== 12'h000) begin errors++; $display("FAIL reset_pred_target got %0h exp 000", pred_target); end
    checks++; if (next_pc !== 12'h104) begin errors++; $display("FAIL reset_next_pc got %0h exp 104", next_pc); end
    tick();
`ifdef BTB_STATS_EN
    checks++; if (stat_ctrl !== 32'd0 || stat_mispred !== 32'd0) begin errors++; $display("FAIL reset_stats got %0h/%0h exp 0/0", stat_ctrl, stat_mispred); end
`endif
  endtask

  task automatic test_cold_lookup();
    RST = 1'b0;
    drive_upd(0, 0, 0, 0, 0, 0, 0);
    pc = 12'h100; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_pred_taken got %0h exp 0", pred_taken); end
    checks++; if (next_pc !== 12'h104) begin errors++; $display("FAIL cold_next_pc got %0h exp 104", next_pc); end
    pc = 12'hFFC; #1;
    checks++; if (next_pc !== 12'h000) begin errors++; $display("FAIL wrap_next_pc got %0h exp 000", next_pc); end
    tick();
  endtask

  task automatic test_allocate();
    pc = 12'h100;
    drive_upd(1, 'h100, 1, 1, 'h040, 0, 0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0h exp 1", mispredict); end
    checks++; if (redirect_pc !== 12'h040) begin errors++; $display("FAIL alloc_redirect got %0h exp 040", redirect_pc); end
    checks++; if (next_pc !== 12'h040) begin errors++; $display("FAIL alloc_next_pc got %0h exp 040", next_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass got %0h exp 0", pred_taken); end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_hit_taken got %0h exp 1", pred_taken); end
    checks++; if (next_pc !== 12'h040) begin errors++; $display("FAIL alloc_hit_next got %0h exp 040", next_pc); end
  endtask

  task automatic test_counter_walk();
    pc = 12'h100;
    for (int k = 0; k < 2; k++) begin
      drive_upd(1, 'h100, 1, 1, 'h040, 1, 'h040); #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL walk_taken%0d_mispredict got %0h exp 0", k, mispredict); end
      tick();
    end
    drive_upd(1, 'h100, 1, 0, 'h040, 1, 'h040); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL walk_nt1_mispredict got %0h exp 1", mispredict); end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL walk_after_nt1_taken got %0h exp 1", pred_taken); end
    drive_upd(1, 'h100, 1, 0, 'h040, 1, 'h040); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL walk_nt2_mispredict got %0h exp 1", mispredict); end
    checks++; if (redirect_pc !== 12'h104) begin errors++; $display("FAIL walk_nt2_redirect got %0h exp 104", redirect_pc); end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL walk_after_nt2_taken got %0h exp 0", pred_taken); end
    checks++; if (next_pc !== 12'h104) begin errors++; $display("FAIL walk_after_nt2_next got %0h exp 104", next_pc); end
  endtask

  task automatic test_target_change();
    pc = 12'h100;
    drive_upd(1, 'h100, 1, 1, 'h040, 0, 0); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_retrain_mispredict got %0h exp 1", mispredict); end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 12'h040) begin errors++; $display("FAIL tgt_before got %0h/%0h exp 1/040", pred_taken, pred_target); end
    drive_upd(1, 'h100, 1, 1, 'h080, 1, 'h040); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_change_mispredict got %0h exp 1", mispredict); end
    checks++; if (redirect_pc !== 12'h080) begin errors++; $display("FAIL tgt_change_redirect got %0h exp 080", redirect_pc); end
    tick();
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_target !== 12'h080) begin errors++; $display("FAIL tgt_after got %0h exp 080", pred_target); end
  endtask

  task automatic test_alias_stale();
    pc = 12'h200;
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_pred_taken got %0h exp 0", pred_taken); end
    checks++; if (next_pc !== 12'h204) begin errors++; $display("FAIL alias_next_pc got %0h exp 204", next_pc); end
    drive_upd(1, 'h100, 0, 0, 0, 1, 'h080); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL stale_mispredict got %0h exp 1", mispredict); end
    checks++; if (redirect_pc !== 12'h104) begin errors++; $display("FAIL stale_redirect got %0h exp 104", redirect_pc); end
    tick();
    pc = 12'h100;
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 12'h000) begin errors++; $display("FAIL stale_invalidated got %0h/%0h exp 0/000", pred_taken, pred_target); end
  endtask

  function automatic int rand_pc();
    int t;
    t = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
    return (t << 8) | ($urandom_range(0, 7) << 2);
  endfunction

  task automatic test_random();
    int up, tg, ptg;
    bit pt, use_model;
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 49) == 0);
      pc  = PC_W'(rand_pc());
      up  = rand_pc();
      tg  = ($urandom_range(0, 1) == 0) ? 'h040 : $urandom_range(0, 1023) * 4;
      use_model = ($urandom_range(0, 3) != 0);
      pt  = use_model ? m_ptaken(up) : 1'($urandom_range(0, 1));
      ptg = use_model ? m_ptarget(up) : $urandom_range(0, 1023) * 4;
      drive_upd(($urandom_range(0, 3) != 0), up, ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), tg, pt, ptg);
      #1;
      checks++; if (pred_taken !== m_ptaken(int'(pc))) begin errors++; $display("FAIL rnd%0d_pred_taken got %0h exp %0h", n, pred_taken, m_ptaken(int'(pc))); end
      checks++; if (pred_target !== PC_W'(m_ptarget(int'(pc)))) begin errors++; $display("FAIL rnd%0d_pred_target got %0h exp %0h", n, pred_target, m_ptarget(int'(pc))); end
      checks++; if (mispredict !== m_mis()) begin errors++; $display("FAIL rnd%0d_mispredict got %0h exp %0h", n, mispredict, m_mis()); end
      checks++; if (redirect_pc !== PC_W'(m_redirect())) begin errors++; $display("FAIL rnd%0d_redirect got %0h exp %0h", n, redirect_pc, m_redirect()); end
      checks++; if (next_pc !== PC_W'(m_next())) begin errors++; $display("FAIL rnd%0d_next_pc got %0h exp %0h", n, next_pc, m_next()); end
`ifdef BTB_STATS_EN
      checks++; if (stat_ctrl !== 32'(m_stat_ctrl) || stat_mispred !== 32'(m_stat_mis)) begin errors++; $display("FAIL rnd%0d_stats got %0d/%0d exp %0d/%0d", n, stat_ctrl, stat_mispred, m_stat_ctrl, m_stat_mis); end
`endif
      tick();
    end
    RST = 1'b0;
  endtask

  task automatic test_reset_midstream();
    RST = 1'b0; pc = 12'h000;
    drive_upd(1, 'h104, 1, 1, 'h010, 0, 0);
    tick();
    RST = 1'b1; pc = 12'h100;
    drive_upd(1, 'h100, 1, 1, 'h040, 0, 0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL midrst_mispredict got %0h exp 0", mispredict); end
    checks++; if (next_pc !== 12'h104) begin errors++; $display("FAIL midrst_next_pc got %0h exp 104", next_pc); end
    tick();
    RST = 1'b0;
    drive_upd(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 12'h000) begin errors++; $display("FAIL midrst_dropped got %0h/%0h exp 0/000", pred_taken, pred_target); end
    pc = 12'h104; #1;
    checks++; if (pred_target !== 12'h000 || next_pc !== 12'h108) begin errors++; $display("FAIL midrst_cold got %0h/%0h exp 000/108", pred_target, next_pc); end
`ifdef BTB_STATS_EN
    checks++; if (stat_ctrl !== 32'd0 || stat_mispred !== 32'd0) begin errors++; $display("FAIL midrst_stats got %0h/%0h exp 0/0", stat_ctrl, stat_mispred); end
`endif
    tick();
  endtask

  initial begin
    RST = 1'b1;
    pc  = '0;
    drive_upd(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    test_reset();
    test_cold_lookup();
    test_allocate();
    test_counter_walk();
    test_target_change();
    test_alias_stale();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_tagged_predictor.md
Name: btb_tagged_predictor

Overview:
Parametrised, tagged, direct-mapped branch target buffer with per-entry 2-bit saturating counters. It generalises the fetch-stage BTB with configurable PC width and depth, valid/tag bits, allocate-on-taken, target-mismatch detection and synchronous table clear.
- Fetch side: combinational lookup producing the next fetch PC.
- EX side: resolves branches/jumps, raises mispredict with a redirect PC, and updates the table on the clock edge.

Parameters:
PC_W, 12, fetch PC width in bits; all PC arithmetic wraps modulo 2^PC_W.
ENTRIES, 64, table depth; power of two, 4..1024.
IDX_W, $clog2(ENTRIES), index width (derived, not overridable).
TAG_W, PC_W-IDX_W-2, tag width (derived); must be >=1.

Ports:
CLK  in  1  clock, posedge active.
RST  in  1  synchronous active-high reset.
pc  in  PC_W  fetch PC for the lookup.
pred_taken  out  1  lookup hit and counter[1]==1.
pred_target  out  PC_W  target of the hit entry; 0 on miss.
next_pc  out  PC_W  next fetch PC.
upd_valid  in  1  EX-stage instruction valid and not stalled.
upd_pc  in  PC_W  PC of the EX-stage instruction.
upd_is_ctrl  in  1  EX instruction is a branch, JAL or JALR.
upd_taken  in  1  resolved direction (JAL/JALR always 1).
upd_target  in  PC_W  resolved target.
upd_pred_taken  in  1  pred_taken carried down the pipeline with the instruction.
upd_pred_target  in  PC_W  pred_target carried down the pipeline.
mispredict  out  1  redirect request.
redirect_pc  out  PC_W  corrected PC; valid when mispredict==1.

Behaviour:
- Addressing: idx = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2]. Entry = {valid, tag, ctr[1:0], target}.
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - next_pc = mispredict ? redirect_pc : (pred_taken ? pred_target : pc+4).
- Mispredict (combinational from the upd_* ports): asserted when upd_valid and any of:
  - upd_is_ctrl & (upd_taken != upd_pred_taken);
  - upd_is_ctrl & upd_taken & upd_pred_taken & (upd_target != upd_pred_target);
  - !upd_is_ctrl & upd_pred_taken (stale or aliased hit).
- redirect_pc = (upd_is_ctrl & upd_taken) ? upd_target : upd_pc+4. This value is also driven when mispredict==0.
- Update at posedge CLK when upd_valid & !RST (index and tag taken from upd_pc):
  - ctrl, hit, taken: ctr saturating +1 (11 holds); target <= upd_target.
  - ctrl, hit, not taken: ctr saturating -1 (00 holds); target unchanged.
  - ctrl, miss, taken: allocate. valid=1, tag written, target=upd_target, ctr=2'b10. Any existing entry at that index is overwritten.
  - ctrl, miss, not taken: no write.
  - !ctrl & hit: valid <= 0.
  - !ctrl & miss: no write.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update entry. There is no bypass; the new value is visible the cycle after the edge.
- Reset:
  - In the cycle RST is sampled high, all valid bits clear and all ctr values go to 2'b01. Targets and tags are don't-care.
  - While RST==1: mispredict=0, pred_taken=0, pred_target=0, next_pc=pc+4.
  - An update presented in the same cycle as RST is dropped.
  - Reset mid-stream requires no drain; the first cycle after reset behaves as a cold table.
- Wrap: pc = 2^PC_W-4 yields next_pc = 0 on a not-taken prediction.

Optional Feature:
Macro BTB_STATS_EN.
- Defined: adds outputs stat_ctrl[31:0] and stat_mispred[31:0].
  - stat_ctrl increments on each upd_valid & upd_is_ctrl.
  - stat_mispred increments on each mispredict.
  - Both saturate at 0xFFFFFFFF and clear on RST. An update dropped by RST is not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package btb_pkg:
  - counter encoding constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111 (the decoder uses these to form upd_is_ctrl);
  - entry struct typedef.
- One sub-module, btb_sat_ctr: a pure combinational 2-bit saturating next-state function (ctr, taken -> ctr_next), instanced in the update path.

Test Plan (PC_W=12, ENTRIES=64):
1. Cold lookup: after reset, pc=0x100 -> pred_taken=0, next_pc=0x104. pc=0xFFC -> next_pc=0x000.
2. Allocate: upd pc=0x100, ctrl, taken, target=0x040, pred_taken=0 -> mispredict=1, redirect_pc=0x040. Next cycle, pc=0x100 -> pred_taken=1, next_pc=0x040.
3. Counter walk: from ctr=10, apply two taken updates -> 11 (saturated). Then one not-taken -> 10, lookup still taken. Then a second not-taken -> 01: mispredict=1, redirect_pc=0x104, subsequent lookup not taken.
4. Target change: entry at 0x100 predicts 0x040; upd taken to 0x080 with pred_target=0x040 -> mispredict=1, redirect_pc=0x080. Next lookup gives pred_target=0x080.
5. Aliasing and stale entry:
   - pc=0x200 (same idx, tag 2) -> miss, next_pc=0x204.
   - upd pc=0x100, !ctrl, pred_taken=1 -> mispredict=1, redirect_pc=0x104; entry invalidated.
6. Reset mid-operation: RST asserted in the same cycle as a taken update to 0x100 -> update dropped and mispredict=0. Next cycle, 0x100 misses. With BTB_STATS_EN: counters read 0.
